intp_deci_mc: RTL and testbench

//  Multi-channel rate adapter between an input sample strobe (eni) and an output strobe (eno).

---
 rtl/intp_deci_pkg.sv | 9 +
 rtl/intp_deci_fifo.sv | 50 +++++
 rtl/intp_deci_mc.sv | 84 ++++++++
 tb/tb_intp_deci_mc.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/intp_deci_pkg.sv
// Shared types for the interpolation/decimation rate adapter.
package intp_deci_pkg;

  typedef enum logic {
    FILL_ZERO = 1'b0,
    FILL_HOLD = 1'b1
  } fill_mode_t;

endpackage

// File: rtl/intp_deci_fifo.sv
// Register-array frame FIFO: DEPTH slots of DW bits, wrapping pointers and an occupancy level.
module intp_deci_fifo
  import intp_deci_pkg::*;
#(
  parameter int DW = 20,
  parameter int DEPTH = 4,
  localparam int LW = $clog2(DEPTH + 1),
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr,
  input  logic          rd,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic [LW-1:0] level
);

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  assign dout = mem[rd_ptr];

  // Storage, pointers and level; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (rd) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({wr, rd})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/intp_deci_mc.sv
// Multi-channel rate adapter: buffers frames on eni, presents one frame per eno,
// zero-stuffing or holding the last frame when the buffer runs dry.
module intp_deci_mc
  import intp_deci_pkg::*;
#(
  parameter int W = 10,
  parameter int CH = 2,
  parameter int DEPTH = 4,
  localparam int LW = $clog2(DEPTH + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       eni,
  input  logic                       eno,
  input  logic                       mode,
  input  logic signed [CH-1:0][W-1:0] in,
  output logic signed [CH-1:0][W-1:0] out,
  output logic                       fill,
  output logic [LW-1:0]              level,
  output logic                       ovf,
  input  logic                       clr_ovf
);

  typedef logic signed [CH-1:0][W-1:0] frame_t;

  frame_t head;
  logic   empty;
  logic   full;
  logic   wr;
  logic   rd;

  assign empty = (level == LW'(0));
  assign full  = (level == LW'(DEPTH));
  assign rd    = eno & ~empty;
  // A read in the same cycle frees the slot, so a full buffer still accepts.
  assign wr    = eni & (~full | eno);

  intp_deci_fifo #(
    .DW    (CH * W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .wr    (wr),
    .rd    (rd),
    .din   (in),
    .dout  (head),
    .level (level)
  );

  // Output frame, fill pulse and sticky overflow flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out  <= '0;
      fill <= 1'b0;
      ovf  <= 1'b0;
    end else begin
      if (eno) begin
        if (!empty) begin
          out  <= head;
          fill <= 1'b0;
        end else begin
          fill <= 1'b1;
          if (fill_mode_t'(mode) == FILL_ZERO) begin
            out <= '0;
          end else begin
            out <= out;
          end
        end
      end else begin
        fill <= 1'b0;
      end

      if (eni & ~eno & full) begin
        ovf <= 1'b1;
      end else if (clr_ovf) begin
        ovf <= 1'b0;
      end else begin
        ovf <= ovf;
      end
    end
  end

endmodule

// File: tb/tb_intp_deci_mc.sv
// Bench for intp_deci_mc: directed scenarios plus random strobes against a queue-based model.
module tb_intp_deci_mc;
  import intp_deci_pkg::*;

  localparam int W = 10;
  localparam int CH = 2;
  localparam int DEPTH = 4;
  localparam int LW = $clog2(DEPTH + 1);
  localparam int FW = CH * W;

  logic               clk = 1'b0;
  logic               rst;
  logic               eni;
  logic               eno;
  logic               mode;
  logic               clr_ovf;
  logic [CH-1:0][W-1:0] in;
  logic [CH-1:0][W-1:0] out;
  logic               fill;
  logic [LW-1:0]      level;
  logic               ovf;

  int n_chk = 0;
  int n_pass = 0;

  logic [FW-1:0] q[$];
  logic [FW-1:0] m_out;
  logic          m_fill;
  logic          m_ovf;

  intp_deci_mc #(.W(W), .CH(CH), .DEPTH(DEPTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .eni     (eni),
    .eno     (eno),
    .mode    (mode),
    .in      (in),
    .out     (out),
    .fill    (fill),
    .level   (level),
    .ovf     (ovf),
    .clr_ovf (clr_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  task automatic check_all();
    chk("out", 64'(out), 64'(m_out));
    chk("fill", 64'(fill), 64'(m_fill));
    chk("level", 64'(level), 64'(q.size()));
    chk("ovf", 64'(ovf), 64'(m_ovf));
  endtask

  // Called at a negedge: drive inputs, advance the model, let one posedge pass, check.
  task automatic step(input bit e_i, input bit e_o, input bit md,
                      input logic [W-1:0] a, input logic [W-1:0] b, input bit clr);
    int pre;
    eni = e_i; eno = e_o; mode = md; clr_ovf = clr;
    in[0] = a; in[1] = b;
    pre = q.size();
    if (e_i && !e_o && pre == DEPTH) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    if (e_o) begin
      if (pre > 0) begin
        m_out = q.pop_front();
        m_fill = 1'b0;
      end else begin
        m_fill = 1'b1;
        if (!md) m_out = '0;
      end
    end else begin
      m_fill = 1'b0;
    end
    if (e_i && (pre < DEPTH || e_o)) q.push_back({b, a});
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  // Assert reset asynchronously with strobes active; they must be ignored.
  task automatic do_reset();
    eni = 1'b1; eno = 1'b1; in[0] = 10'd9; in[1] = 10'd9;
    rst = 1'b1;
    #1;
    q.delete();
    m_out = '0; m_fill = 1'b0; m_ovf = 1'b0;
    check_all();
    @(negedge clk);
    check_all();
    eni = 1'b0; eno = 1'b0;
    rst = 1'b0;
  endtask

  initial begin
    logic [W-1:0] r;
    rst = 1'b1; eni = 1'b0; eno = 1'b0; mode = 1'b0; clr_ovf = 1'b0; in = '0;
    m_out = '0; m_fill = 1'b0; m_ovf = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_all();
    rst = 1'b0;

    // Reset mid-stream with three frames buffered.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, W'(i + 1), W'(i + 11), 1'b0);
    chk("lvl3_before_rst", 64'(level), 64'd3);
    do_reset();

    // Interpolate x4, zero fill then hold fill.
    for (int m = 0; m < 2; m++)
      for (int i = 0; i < 16; i++)
        step(i % 4 == 0, 1'b1, m[0], 10'd5, 10'h3FD, 1'b0);

    // Decimate: ramp every cycle, eno every other cycle, then clear ovf.
    for (int i = 0; i < 20; i++) begin
      r = W'(i);
      step(1'b1, i % 2 == 1, 1'b0, r, ~r, 1'b0);
    end
    chk("decim_ovf", 64'(ovf), 64'd1);
    step(1'b0, 1'b0, 1'b0, 10'd0, 10'd0, 1'b1);
    chk("decim_clr", 64'(ovf), 64'd0);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b0, 10'd0, 10'd0, 1'b0);

    // Simultaneous strobes on an empty buffer: no bypass.
    step(1'b1, 1'b1, 1'b0, 10'd7, 10'd7, 1'b0);
    chk("simul_fill", 64'(fill), 64'd1);
    chk("simul_out", 64'(out), 64'd0);
    chk("simul_lvl", 64'(level), 64'd1);
    step(1'b0, 1'b1, 1'b0, 10'd0, 10'd0, 1'b0);
    chk("simul_out2", 64'(out[0]), 64'd7);

    // Full buffer with both strobes: no overflow, level stays at DEPTH.
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 1'b1, W'(100 + i), W'(200 + i), 1'b0);
    step(1'b1, 1'b1, 1'b1, 10'd300, 10'd301, 1'b0);
    chk("full_both_lvl", 64'(level), 64'(DEPTH));
    chk("full_both_ovf", 64'(ovf), 64'd0);
    chk("full_both_out", 64'(out[0]), 64'd100);
    for (int i = 0; i < 3 * DEPTH; i++) step(1'b1, 1'b1, 1'b1, W'(i), W'(i + 50), 1'b0);

    // Random strobes with varying rate ratios, occasional clear and reset.
    for (int ph = 0; ph < 8; ph++) begin
      int pi, po;
      pi = $urandom_range(10, 90);
      po = $urandom_range(10, 90);
      for (int i = 0; i < 200; i++) begin
        step($urandom_range(0, 99) < pi, $urandom_range(0, 99) < po, $urandom_range(0, 1) == 1,
             W'($urandom), W'($urandom), $urandom_range(0, 19) == 0);
        if ($urandom_range(0, 299) == 0) do_reset();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
